axis_mover: RTL
===============

Name: axis_mover

Overview:
Parametrised successor to the single-axis block position register. It holds one coordinate of the moving block and advances it on VGA-synchronised tick pulses. Step size, speed divider, range and edge behaviour (bounce, wrap, stop) are configurable, and edge events are reported to the game FSM. Instantiated once per axis in the datapath.

Parameters:
POS_W, 8, coordinate width in bits
POS_MIN, 0, lowest legal coordinate
POS_MAX, 144, highest legal coordinate; POS_MIN < POS_MAX < 2^POS_W
STEP_W, 3, width of step-magnitude input
DIV_W, 4, width of speed-divider input
RESET_POS, 0, coordinate after reset; must lie in [POS_MIN, POS_MAX]

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
sync  in  1  one-clk tick pulse from VGA timing; movement is evaluated only on sync=1
enable  in  1  movement enable
mode  in  2  edge mode: 00 bounce, 01 wrap, 10 stop, 11 treated as bounce
step  in  STEP_W  pixels moved per move event
div  in  DIV_W  move on every (div+1)th qualifying sync
load_pos  in  1  load new_pos
new_pos  in  POS_W  coordinate to load
load_dir  in  1  load new_dir
new_dir  in  1  0 = toward POS_MIN (left), 1 = toward POS_MAX (right)
pos  out  POS_W  current coordinate
dir  out  1  current direction
edge_hit  out  1  one-clk pulse on any bounce, wrap or stop event
halted  out  1  high while in HALT state

Behaviour:
- All state changes occur on posedge clk. Reset overrides everything: pos=RESET_POS, dir=1, edge_hit=0, halted=0, div counter=0, state=RUN.
- States: RUN, HALT. RUN->HALT only on a stop-mode edge event. HALT->RUN on load_pos or load_dir. In HALT, pos and dir hold and sync is ignored.
- Loads: load_pos sets pos=clamp(new_pos, POS_MIN, POS_MAX) and clears the div counter. load_dir sets dir=new_dir. Both may occur in the same cycle. Any load in a cycle suppresses a move in that cycle; loads always win.
- Qualifying sync: sync=1, enable=1, state=RUN, no load. The div counter increments on each qualifying sync. When counter==div, a move event fires and the counter returns to 0. With div=0, every qualifying sync moves. enable=0 clears the counter.
- Move arithmetic uses POS_W+1 bits, no overflow. s=step. The target is t = pos+s (dir=1) or pos−s (dir=0, computed as signed).
- Step 0: the move event is consumed, pos and dir are unchanged, no edge_hit.
- In range (POS_MIN ≤ t ≤ POS_MAX): pos=t, no edge_hit. Landing exactly on a bound is not an edge event.
- Out of range, bounce mode: pos clamps to the violated bound, dir inverts, edge_hit=1.
- Out of range, wrap mode: pos = t − (POS_MAX−POS_MIN+1) when over the top, or t + (POS_MAX−POS_MIN+1) when under the bottom. dir is unchanged and edge_hit=1. step must be ≤ POS_MAX−POS_MIN+1.
- Out of range, stop mode: pos clamps to the bound, dir is unchanged, edge_hit=1, state=HALT.
- Already sitting on a bound and moving outward with s>0 is out of range and handled as above. This covers the earlier single-pixel bounce at 0/144.
- edge_hit is registered and high exactly one clk after the move cycle; otherwise it is 0.
- mode and step are sampled only on the move cycle, so changing them mid-flight is legal.
- Reset asserted mid-count or in HALT returns to the reset state on the next edge.

Test Plan:
- Reset: assert reset 2 clks -> pos=0, dir=1, halted=0, edge_hit=0. Then 3 syncs with enable=1, step=1, div=0 -> pos=1,2,3.
- Bounce: load_pos=142, dir=1, step=4, mode=00, one sync -> pos=144, dir=0, edge_hit pulse. Next sync -> pos=140.
- Wrap: load_pos=143, step=3, mode=01, dir=1, one sync -> pos=1, dir=1, edge_hit=1. Then load_dir=0, load_pos=1, sync -> pos=143.
- Stop/HALT: load_pos=2, dir=0, step=5, mode=10, sync -> pos=0, halted=1. Then 4 more syncs -> pos=0. Then load_dir=1 -> halted=0, and the next sync gives pos=5.
- Divider/enable: div=2, step=1, pos=10 -> pos changes only on the 3rd and 6th syncs (11, 12). enable=0 after the 1st sync of a count, re-enable -> the count restarts from 0.
- Load priority: sync and load_pos=200 in the same cycle -> pos=144 (clamped), no move, counter cleared, no edge_hit.

Source files
------------

// File: rtl/axis_mover.sv
// axis_mover: one coordinate of the moving block. The position advances on
// qualifying VGA sync ticks, at a configurable step size and speed divider.
// At the edges of [POS_MIN, POS_MAX] it bounces, wraps or stops, and reports
// each edge event with a single-cycle edge_hit pulse.
module axis_mover #(
    parameter int unsigned POS_W     = 8,
    parameter int          POS_MIN   = 0,
    parameter int          POS_MAX   = 144,
    parameter int unsigned STEP_W    = 3,
    parameter int unsigned DIV_W     = 4,
    parameter int          RESET_POS = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [DIV_W-1:0]  div,
    input  logic              load_pos,
    input  logic [POS_W-1:0]  new_pos,
    input  logic              load_dir,
    input  logic              new_dir,
    output logic [POS_W-1:0]  pos,
    output logic              dir,
    output logic              edge_hit,
    output logic              halted
);

    // Signed working width: wide enough for pos +/- step with no overflow.
    localparam int unsigned EXT_W = ((POS_W >= STEP_W) ? POS_W : STEP_W) + 2;

    localparam logic signed [EXT_W-1:0] MIN_S   = EXT_W'(POS_MIN);
    localparam logic signed [EXT_W-1:0] MAX_S   = EXT_W'(POS_MAX);
    localparam logic signed [EXT_W-1:0] RANGE_S = EXT_W'(POS_MAX - POS_MIN + 1);

    localparam logic [1:0] MODE_WRAP = 2'b01;
    localparam logic [1:0] MODE_STOP = 2'b10;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               dir_q, dir_d;
    logic               edge_hit_q, edge_hit_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;

    logic                    any_load;
    logic                    move;
    logic signed [EXT_W-1:0] pos_ext;
    logic signed [EXT_W-1:0] step_ext;
    logic signed [EXT_W-1:0] np_ext;
    logic signed [EXT_W-1:0] tgt;

    // State register: synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pos_q      <= POS_W'(RESET_POS);
            dir_q      <= 1'b1;
            edge_hit_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            edge_hit_q <= edge_hit_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next state: loads take priority, then divider, then move and edge handling.
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        edge_hit_d = 1'b0;
        cnt_d      = cnt_q;
        move       = 1'b0;
        any_load   = load_pos | load_dir;
        pos_ext    = signed'(EXT_W'(pos_q));
        step_ext   = signed'(EXT_W'(step));
        np_ext     = signed'(EXT_W'(new_pos));
        tgt        = dir_q ? (pos_ext + step_ext) : (pos_ext - step_ext);

        if (!enable) begin
            cnt_d = '0;
        end

        if (load_pos) begin
            cnt_d = '0;
            if (np_ext < MIN_S) begin
                pos_d = POS_W'(POS_MIN);
            end else if (np_ext > MAX_S) begin
                pos_d = POS_W'(POS_MAX);
            end else begin
                pos_d = new_pos;
            end
        end

        if (load_dir) begin
            dir_d = new_dir;
        end

        if (any_load) begin
            state_d = ST_RUN;
        end else if (state_q == ST_RUN && sync && enable) begin
            if (cnt_q == div) begin
                cnt_d = '0;
                move  = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end

        // A zero step consumes the move event without touching pos or dir.
        if (move && step != '0) begin
            if (tgt > MAX_S) begin
                edge_hit_d = 1'b1;
                if (mode == MODE_WRAP) begin
                    pos_d = POS_W'(tgt - RANGE_S);
                end else begin
                    pos_d = POS_W'(POS_MAX);
                    if (mode == MODE_STOP) begin
                        state_d = ST_HALT;
                    end else begin
                        dir_d = ~dir_q;
                    end
                end
            end else if (tgt < MIN_S) begin
                edge_hit_d = 1'b1;
                if (mode == MODE_WRAP) begin
                    pos_d = POS_W'(tgt + RANGE_S);
                end else begin
                    pos_d = POS_W'(POS_MIN);
                    if (mode == MODE_STOP) begin
                        state_d = ST_HALT;
                    end else begin
                        dir_d = ~dir_q;
                    end
                end
            end else begin
                pos_d = POS_W'(tgt);
            end
        end
    end

    assign pos      = pos_q;
    assign dir      = dir_q;
    assign edge_hit = edge_hit_q;
    assign halted   = (state_q == ST_HALT);

endmodule
